// File: rtl/misaligned_access_unit_pkg.sv
// misaligned_access_unit_pkg: access-size encodings, FSM state encoding and the size-to-byte-count helper
package misaligned_access_unit_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [2:0] {IDLE, ACC1, ACC2, CAP, RESP} state_t;
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    return size == SZ_BYTE ? 3'd1 : size == SZ_HALF ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/misaligned_access_unit_byte_lane_align.sv
// byte_lane_align: per-word lane enables/store data (offset,size,second,wdata -> be,wdata_lane) and load extraction (rd_first,rd_second,is_unsigned -> ldata)
module byte_lane_align
  import misaligned_access_unit_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic        second,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_first,
  input  logic [31:0] rd_second,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] ldata
);
  logic [2:0]  n;
  logic [7:0]  mask;
  logic [63:0] wide_w;
  logic [63:0] wide_r;
  always_comb begin
    n = size_bytes(size);
    mask = ((8'd1 << n) - 8'd1) << offset;
    wide_w = {32'd0, wdata} << {offset, 3'b000};
    wide_r = {rd_second, rd_first} >> {offset, 3'b000};
    be = second ? mask[7:4] : mask[3:0];
    wdata_lane = second ? wide_w[63:32] : wide_w[31:0];
    ldata = n == 3'd1 ? {{24{~is_unsigned & wide_r[7]}}, wide_r[7:0]} :
            n == 3'd2 ? {{16{~is_unsigned & wide_r[15]}}, wide_r[15:0]} :
            wide_r[31:0];
  end
endmodule

// File: rtl/misaligned_access_unit.sv
// misaligned_access_unit: splits byte/half/word core requests (req_*) into one or two aligned word accesses (mem_*), returns extended load data (resp_*)
module misaligned_access_unit
  import misaligned_access_unit_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  state_t            state, state_nx;
  logic              write_q, uns_q, cross_q;
  logic [1:0]        size_q, off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, first_q;
  logic              accept, cross_req, acc;
  logic [3:0]        be_lane;
  logic [31:0]       wdata_lane, ldata;
  logic              unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];
  assign accept = state == IDLE && req_valid;
  assign cross_req = {1'b0, req_addr[1:0]} + size_bytes(req_size) > 3'd4;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = req_valid ? ACC1 : IDLE;
      ACC1:    state_nx = cross_q ? ACC2 : write_q ? RESP : CAP;
      ACC2:    state_nx = write_q ? RESP : CAP;
      CAP:     state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    acc = state == ACC1 || state == ACC2;
    req_ready = state == IDLE;
    resp_valid = state == RESP;
    mem_addr = state == ACC1 ? addr_q : state == ACC2 ? addr_q + ADDR_W'(1) : '0;
    mem_wen = acc && write_q;
    mem_be = !acc ? 4'b0000 : write_q ? be_lane : 4'b1111;
    mem_wdata = mem_wen ? wdata_lane : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      write_q <= 1'b0;
      uns_q <= 1'b0;
      cross_q <= 1'b0;
      size_q <= 2'b00;
      off_q <= 2'b00;
      addr_q <= '0;
      wdata_q <= 32'd0;
      first_q <= 32'd0;
      resp_rdata <= 32'd0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        uns_q <= req_unsigned;
        cross_q <= cross_req;
        size_q <= req_size;
        off_q <= req_addr[1:0];
        addr_q <= req_addr[ADDR_W+1:2];
        wdata_q <= req_wdata;
        resp_rdata <= 32'd0;
      end
      if (state == ACC2) first_q <= mem_rdata;
      if (state == CAP) resp_rdata <= ldata;
    end
  end
  // In CAP a crossing load has its first word parked in first_q and the second arriving now
  byte_lane_align u_align (
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .second      (state == ACC2),
    .wdata       (wdata_q),
    .rd_first    (cross_q ? first_q : mem_rdata),
    .rd_second   (mem_rdata),
    .be          (be_lane),
    .wdata_lane  (wdata_lane),
    .ldata       (ldata)
  );
endmodule

// File: tb/tb_misaligned_access_unit.sv
// tb_misaligned_access_unit: scoreboard bench with a byte-addressed reference memory against a word-banked memory model
module tb_misaligned_access_unit;
  localparam int ADDR_W = 8;
  localparam int NW = 1 << ADDR_W;
  localparam int NB = NW * 4;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [31:0]       req_addr = 32'd0;
  logic [31:0]       req_wdata = 32'd0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = 32'd0;
  bit [31:0]         mem [NW];
  byte unsigned      model_mem [NB];
  int                cyc = 0;
  int                checks = 0;
  int                failures = 0;
  typedef struct {logic [31:0] rdata; int due;} exp_t;
  exp_t              sb [$];

  misaligned_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_wen && mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    mem_rdata <= mem[mem_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp: got resp_valid=1 rdata=%h expected no response (cycle %0d)", resp_rdata, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_cycle", 32'(cyc), 32'(e.due));
        end
      end
    end
  endtask

  // Called at a negedge; returns at the negedge of the first access cycle.
  task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input bit track);
    int b, n, lat, base, idx;
    logic [31:0] r;
    req_valid = 1'b1;
    req_write = w;
    req_size = sz;
    req_unsigned = uns;
    req_addr = a;
    req_wdata = wd;
    b = 0;
    while (!req_ready && b < 20) begin
      @(negedge clk);
      b++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: req_ready=0 after %0d cycles, required 1", b);
    end else if (track) begin
      n = sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
      base = int'(a[ADDR_W+1:0]);
      lat = (w ? 2 : 3) + ((base % 4) + n > 4 ? 1 : 0);
      r = 32'd0;
      for (int i = 0; i < n; i++) begin
        idx = (base + i) % NB;
        if (w) model_mem[idx] = wd[8*i +: 8];
        else r = r | (32'(model_mem[idx]) << (8 * i));
      end
      if (!w && !uns && n < 4 && r[8*n-1]) r = r | (32'hFFFF_FFFF << (8 * n));
      sb.push_back('{r, cyc + lat});
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic port(input string name, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wdata, input logic wen);
    check({name, "_addr"}, 32'(mem_addr), addr);
    check({name, "_be"}, 32'(mem_be), 32'(be));
    if (wen) check({name, "_wdata"}, mem_wdata, wdata);
    check({name, "_wen"}, 32'(mem_wen), 32'(wen));
  endtask

  initial begin
    int wait_b;
    logic [31:0] a;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    port("rst", 32'd0, 4'b0000, 32'd0, 1'b0);
    check("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 1'b1);
    port("wst", 32'd4, 4'b1111, 32'h1234_5678, 1'b1);
    check("busy_ready", 32'(req_ready), 32'd0);
    issue(1'b1, 2'b01, 1'b0, 32'h15, 32'h0000_330f, 1'b1);
    port("hst", 32'd5, 4'b0110, 32'h0033_0f00, 1'b1);
    @(negedge clk);
    check("hst_single_write", 32'(mem_wen), 32'd0);
    issue(1'b1, 2'b10, 1'b0, 32'h14, 32'h4433_2211, 1'b1);
    issue(1'b1, 2'b10, 1'b0, 32'h18, 32'h8877_6655, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h17, 32'd0, 1'b1);
    port("wld1", 32'd5, 4'b1111, 32'd0, 1'b0);
    @(negedge clk);
    port("wld2", 32'd6, 4'b1111, 32'd0, 1'b0);
    issue(1'b1, 2'b10, 1'b0, 32'h14, 32'h0080_0000, 1'b1);
    issue(1'b0, 2'b00, 1'b0, 32'h16, 32'd0, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 32'h16, 32'd0, 1'b1);
    issue(1'b1, 2'b01, 1'b0, 32'h3FF, 32'h0000_BEEF, 1'b1);
    port("wrap1", 32'd255, 4'b1000, 32'hEF00_0000, 1'b1);
    @(negedge clk);
    port("wrap2", 32'd0, 4'b0001, 32'h0000_00BE, 1'b1);
    issue(1'b1, 2'b10, 1'b0, 32'h24, 32'hA5A5_A5A5, 1'b1);
    issue(1'b1, 2'b10, 1'b0, 32'h21, 32'hCAFE_BABE, 1'b0);
    check("rst_mid_wen_before", 32'(mem_wen), 32'd1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) model_mem[16'h21 + i] = 8'(32'hCAFE_BABE >> (8 * i));
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_wen", 32'(mem_wen), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("rst_mid_second_word", mem[9], 32'hA5A5_A5A5);
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a = $urandom_range(0, 1) ? 32'($urandom_range(0, 63)) : 32'($urandom_range(NB - 64, NB - 1));
      a = a | ($urandom & ~32'(NB - 1));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom, 1'b1);
    end
    wait_b = 0;
    while (sb.size() != 0 && wait_b < 20) begin
      @(negedge clk);
      wait_b++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
    end
    for (int j = 0; j < NW; j++)
      check("mem_word", mem[j], {model_mem[4*j+3], model_mem[4*j+2], model_mem[4*j+1], model_mem[4*j]});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/misaligned_access_unit.md
MISALIGNED_ACCESS_UNIT -- requirements
Module: misaligned_access_unit

Interface
REQ-001 Parameter: ADDR_W, default 8, word-address width of data memory (byte address space = 2^(ADDR_W+2)).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  core presents load/store request.
REQ-005 req_ready  output  1  unit accepts request this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-008 req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-009 req_addr  input  32  byte address; bits above ADDR_W+1 ignored.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle completion pulse, loads and stores; no backpressure.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores.
REQ-013 mem_addr  output  ADDR_W  aligned word address to banked memory.
REQ-014 mem_wen  output  1  write strobe.
REQ-015 mem_be  output  4  byte-lane enables; lane i = byte offset i (little-endian).
REQ-016 mem_wdata  output  32  lane-positioned write data.
REQ-017 mem_rdata  input  32  read word, valid the cycle after mem_addr is presented.

Function
REQ-018 States SHALL be IDLE, ACC1, ACC2, CAP, RESP; req_ready = 1 only in IDLE.
REQ-019 IDLE: on req_valid, latch all request fields; offset = addr[1:0], n = 1/2/4 bytes, cross = (offset+n > 4); next ACC1.
REQ-020 ACC1: mem_addr = addr[ADDR_W+1:2]; next ACC2 if cross, else CAP for loads, RESP for stores.
REQ-021 ACC2: mem_addr = first word + 1 modulo 2^ADDR_W (wrap from max index to 0); capture mem_rdata as first word; next CAP (load) or RESP (store).
REQ-022 CAP: capture mem_rdata as last word, assemble and register resp_rdata; next RESP.
REQ-023 RESP: resp_valid = 1 for exactly one cycle; next IDLE; request presented in RESP is not accepted until IDLE.
REQ-024 Latency from accept cycle T: load non-crossing resp at T+3, crossing T+4; store non-crossing T+2, crossing T+3.
REQ-025 Store first word: mem_be lanes offset..min(3, offset+n-1); mem_wdata = wdata << 8*offset.
REQ-026 Store second word: mem_be lanes 0..(offset+n-5); mem_wdata = wdata >> 8*(4-offset).
REQ-027 mem_wen = 1 only in ACC1/ACC2 of a store; loads drive mem_be = 1111, mem_wen = 0; outside ACC1/ACC2 mem_wen = 0, mem_be = 0.
REQ-028 Load assembly: ({second, first} >> 8*offset), keep low n bytes, extend per req_unsigned; non-crossing uses first only.

Reset
REQ-029 rst SHALL force IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, mem_wen = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0.
REQ-030 rst mid-operation SHALL abandon the access: no further write strobe, no resp_valid for it; rst has priority over req_valid.

Structure
REQ-031 Shared package holds size encodings (SZ_BYTE/HALF/WORD) and state encoding.
REQ-032 One combinational sub-module byte_lane_align computes be/wdata per word and load extraction/extension; FSM in top.

Verification
REQ-033 Word store 0x12345678 @0x10 -> T+1: mem_addr 4, be 1111, wdata 0x12345678, wen 1; resp_valid T+2.
REQ-034 Half store 0x330f @0x15 -> single write addr 5, be 0110, wdata 0x00330f00; resp_valid T+2.
REQ-035 Word load @0x17, word5 = 0x44332211, word6 = 0x88776655 -> reads addr 5 then 6; resp_rdata 0x77665544 at T+4.
REQ-036 Byte load @0x16, word5 = 0x00800000 -> signed 0xFFFFFF80, unsigned 0x00000080, resp at T+3.
REQ-037 ADDR_W=8 half store 0xBEEF @0x3FF -> word 255 be 1000 wdata 0xEF000000, then word 0 be 0001 wdata 0x000000BE.
REQ-038 rst asserted during ACC1 of crossing store -> next cycle mem_wen 0, req_ready 1, no resp_valid; second word untouched.
